pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage 64-bit pipeline.
- Drives write-enables, flushes and bubble-injects for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves three hazard classes: load-use, taken branch resolved in MEM, and a multi-cycle data-memory req/ack handshake.
- Keeps saturating stall/flush event counters and a sticky memory-timeout flag.

---
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, MEM-stage branch
// flush and multi-cycle data-memory waits, with saturating event counters.
module pipeline_hazard_ctrl #(
   parameter int CNT_W    = 32,
   parameter int MAX_WAIT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       ifid_rs1,
   input  logic [4:0]       ifid_rs2,
   input  logic [4:0]       idex_rd,
   input  logic             idex_memread,
   input  logic             exmem_memread,
   input  logic             exmem_memwrite,
   input  logic             branch_taken,
   input  logic             dmem_ack,
   output logic             dmem_req,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_write,
   output logic             exmem_flush,
   output logic             memwb_bubble,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [7:0]       MAX_WAIT_C = 8'(MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;

   logic memop;
   logic rs_match;
   logic mem_stall;
   logic br_flush;
   logic load_use;
   logic pc_stall;

   // Hazard classification with priority memory stall > branch flush > load-use
   always_comb begin
      memop    = exmem_memread | exmem_memwrite;
      rs_match = (idex_rd == ifid_rs1) | (idex_rd == ifid_rs2);
      case (state_q)
         RUN:      mem_stall = memop & ~dmem_ack;
         MEM_WAIT: mem_stall = ~dmem_ack;
         default:  mem_stall = 1'b0;
      endcase
      br_flush = ~mem_stall & branch_taken;
      load_use = ~mem_stall & ~branch_taken & idex_memread &
                 (idex_rd != 5'd0) & rs_match;
      pc_stall = mem_stall | load_use;
   end

   // Pipeline control outputs, forced low while reset is asserted
   always_comb begin
      dmem_req     = 1'b0;
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_write  = 1'b0;
      exmem_flush  = 1'b0;
      memwb_bubble = 1'b0;
      if (!reset) begin
         dmem_req     = memop;
         pc_write     = ~pc_stall;
         ifid_write   = ~pc_stall;
         ifid_flush   = br_flush;
         idex_flush   = br_flush | load_use;
         exmem_write  = ~mem_stall;
         exmem_flush  = br_flush;
         memwb_bubble = mem_stall;
      end else begin
         dmem_req     = 1'b0;
         memwb_bubble = 1'b0;
      end
   end

   // Next-state: memory wait tracking, timeout flag and event counters
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      case (state_q)
         RUN: begin
            if (memop && !dmem_ack) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = 8'd1;
            end else begin
               state_d    = RUN;
               wait_cnt_d = 8'd0;
            end
         end
         MEM_WAIT: begin
            if (dmem_ack) begin
               state_d    = RUN;
               wait_cnt_d = 8'd0;
            end else begin
               state_d = MEM_WAIT;
               if (wait_cnt_q != 8'hFF) begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end else begin
                  wait_cnt_d = wait_cnt_q;
               end
               // Flag is sticky; only reset clears it
               if (wait_cnt_q == MAX_WAIT_C) begin
                  mem_timeout_d = 1'b1;
               end else begin
                  mem_timeout_d = mem_timeout_q;
               end
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = 8'd0;
         end
      endcase
      if (pc_stall && (stall_count_q != CNT_MAX)) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end else begin
         stall_count_d = stall_count_q;
      end
      if (br_flush && (flush_count_q != CNT_MAX)) begin
         flush_count_d = flush_count_q + CNT_W'(1);
      end else begin
         flush_count_d = flush_count_q;
      end
   end

   // State registers with asynchronous active-high reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= RUN;
         wait_cnt_q    <= 8'd0;
         mem_timeout_q <= 1'b0;
         stall_count_q <= {CNT_W{1'b0}};
         flush_count_q <= {CNT_W{1'b0}};
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign mem_timeout = mem_timeout_q;
   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table, hand
// sequences for wait/timeout/reset corners, and random stimulus vs. a model.
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W    = 4;
   localparam int MAX_WAIT = 4;
   localparam int SAT      = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [4:0]       ifid_rs1 = 5'd0, ifid_rs2 = 5'd0, idex_rd = 5'd0;
   logic             idex_memread = 1'b0, exmem_memread = 1'b0, exmem_memwrite = 1'b0;
   logic             branch_taken = 1'b0, dmem_ack = 1'b0;
   logic             dmem_req, pc_write, ifid_write, ifid_flush, idex_flush;
   logic             exmem_write, exmem_flush, memwb_bubble, mem_timeout;
   logic [CNT_W-1:0] stall_count, flush_count;

   pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_rd(idex_rd),
      .idex_memread(idex_memread), .exmem_memread(exmem_memread),
      .exmem_memwrite(exmem_memwrite), .branch_taken(branch_taken),
      .dmem_ack(dmem_ack), .dmem_req(dmem_req), .pc_write(pc_write),
      .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_write(exmem_write), .exmem_flush(exmem_flush),
      .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state: are we waiting on memory, how long, and event tallies
   bit m_waiting;
   int m_waited;
   bit m_to;
   int m_stall;
   int m_flush;

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       idex_mr, ex_mr, ex_mw, bt, ack;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[10];

   // Order: dmem_req pc_write ifid_write ifid_flush idex_flush exmem_write exmem_flush memwb_bubble
   function automatic logic [7:0] dut_comb();
      return {dmem_req, pc_write, ifid_write, ifid_flush, idex_flush,
              exmem_write, exmem_flush, memwb_bubble};
   endfunction

   function automatic bit model_mem_stall();
      bit memop = exmem_memread | exmem_memwrite;
      return !dmem_ack && (m_waiting || memop);
   endfunction

   function automatic bit model_load_use();
      return !model_mem_stall() && !branch_taken && idex_memread && idex_rd != 5'd0 &&
             (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
   endfunction

   function automatic logic [7:0] model_comb();
      bit ms  = model_mem_stall();
      bit br  = !ms && branch_taken;
      bit lu  = model_load_use();
      bit pcw = !(ms || lu);
      return {exmem_memread | exmem_memwrite, pcw, pcw, br, br | lu, !ms, br, ms};
   endfunction

   task automatic model_update();
      bit ms  = model_mem_stall();
      bit br  = !ms && branch_taken;
      bit pcw = !(ms || model_load_use());
      if (ms) begin
         if (m_waiting) begin
            if (m_waited == MAX_WAIT) m_to = 1'b1;
            if (m_waited < 255) m_waited++;
         end else begin
            m_waiting = 1'b1;
            m_waited  = 1;
         end
      end else begin
         m_waiting = 1'b0;
         m_waited  = 0;
      end
      if (!pcw && m_stall < SAT) m_stall++;
      if (br && m_flush < SAT) m_flush++;
   endtask

   task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, got, exp);
      end
   endtask

   // One clock: compare at negedge, then advance model on posedge; inputs change at posedge+1
   task automatic step(string nm, bit has_exp, logic [7:0] exp);
      @(negedge clk);
      if (has_exp) check({nm, "_tab"}, 32'(dut_comb()), 32'(exp));
      check({nm, "_comb"}, 32'(dut_comb()), 32'(model_comb()));
      check({nm, "_regs"}, 32'({mem_timeout, stall_count, flush_count}),
            32'({m_to, 4'(m_stall), 4'(m_flush)}));
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_outs", 32'(dut_comb()), 32'd0);
      check("rst_regs", 32'({mem_timeout, stall_count, flush_count}), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      m_waiting = 1'b0; m_waited = 0; m_to = 1'b0; m_stall = 0; m_flush = 0;
   endtask

   task automatic idle_inputs();
      ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; idex_rd = 5'd0; idex_memread = 1'b0;
      exmem_memread = 1'b0; exmem_memwrite = 1'b0; branch_taken = 1'b0; dmem_ack = 1'b0;
   endtask

   initial begin
      tbl[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0110_0100}; // idle
      tbl[1] = '{5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_1100}; // load-use rs2
      tbl[2] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0110_0100}; // rd=x0
      tbl[3] = '{5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_1100}; // load-use rs1
      tbl[4] = '{5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0110_0100}; // not a load
      tbl[5] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'b1110_0100}; // zero-wait store
      tbl[6] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'b1110_0100}; // zero-wait load
      tbl[7] = '{5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'b0111_1110}; // branch beats load-use
      tbl[8] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b0110_0100}; // spurious ack
      tbl[9] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'b1111_1110}; // branch + zero-wait

      do_reset();
      foreach (tbl[i]) begin
         ifid_rs1 = tbl[i].rs1; ifid_rs2 = tbl[i].rs2; idex_rd = tbl[i].rd;
         idex_memread = tbl[i].idex_mr; exmem_memread = tbl[i].ex_mr;
         exmem_memwrite = tbl[i].ex_mw; branch_taken = tbl[i].bt; dmem_ack = tbl[i].ack;
         step($sformatf("vec%0d", i), 1'b1, tbl[i].exp);
      end
      check("tbl_stall_cnt", 32'(stall_count), 32'd2);
      check("tbl_flush_cnt", 32'(flush_count), 32'd2);

      // 3-cycle load, ack on the 4th cycle
      idle_inputs();
      do_reset();
      exmem_memread = 1'b1;
      for (int i = 0; i < 3; i++) step("ld3_wait", 1'b1, 8'b1000_0001);
      dmem_ack = 1'b1;
      step("ld3_ack", 1'b1, 8'b1110_0100);
      check("ld3_stall_cnt", 32'(stall_count), 32'd3);
      check("ld3_timeout", 32'(mem_timeout), 32'd0);
      dmem_ack = 1'b0; exmem_memread = 1'b0;
      step("ld3_after", 1'b1, 8'b0110_0100);

      // Timeout, branch held through a wait, stall counter saturation
      do_reset();
      exmem_memread = 1'b1;
      step("to_run", 1'b1, 8'b1000_0001);
      branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) step("to_wait", 1'b1, 8'b1000_0001);
      check("to_not_yet", 32'(mem_timeout), 32'd0);
      step("to_wait4", 1'b1, 8'b1000_0001);
      check("to_set", 32'(mem_timeout), 32'd1);
      for (int i = 0; i < 15; i++) step("to_more", 1'b1, 8'b1000_0001);
      check("to_stall_sat", 32'(stall_count), 32'(SAT));
      dmem_ack = 1'b1;
      step("to_ack_flush", 1'b1, 8'b1111_1110);
      check("to_flush_once", 32'(flush_count), 32'd1);
      idle_inputs();
      for (int i = 0; i < 3; i++) step("to_idle", 1'b1, 8'b0110_0100);
      check("to_sticky", 32'(mem_timeout), 32'd1);
      check("to_flush_cnt", 32'(flush_count), 32'd1);

      // Reset in the middle of a wait with hazards still asserted
      exmem_memread = 1'b1; branch_taken = 1'b1; idex_memread = 1'b1;
      idex_rd = 5'd3; ifid_rs1 = 5'd3;
      step("rw_run", 1'b1, 8'b1000_0001);
      step("rw_wait", 1'b1, 8'b1000_0001);
      do_reset();
      check("rw_timeout_clr", 32'(mem_timeout), 32'd0);
      check("rw_cnt_clr", 32'({stall_count, flush_count}), 32'd0);
      step("rw_run_again", 1'b1, 8'b1000_0001);

      // Random stimulus against the model
      idle_inputs();
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         ifid_rs1       = 5'($urandom_range(0, 3));
         ifid_rs2       = 5'($urandom_range(0, 3));
         idex_rd        = 5'($urandom_range(0, 3));
         idex_memread   = 1'($urandom_range(0, 1));
         exmem_memread  = ($urandom_range(0, 3) == 0);
         exmem_memwrite = ($urandom_range(0, 5) == 0);
         branch_taken   = ($urandom_range(0, 4) == 0);
         dmem_ack       = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 299) == 0) do_reset();
         else step("rnd", 1'b0, 8'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
